// File: rtl/mem_channel_arb.sv
// mem_channel_arb
// N-channel memory-bus arbiter. Requests from several cache-side channels are
// multiplexed onto one DDR command port, with one transaction outstanding at a time.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//    defined     -> round-robin winner selection starting at a rotating pointer
//    not defined -> fixed priority, lowest-numbered valid channel wins
// A per-channel flush suppresses the completion pulse of the granted channel.
// The DDR transaction itself always runs to the end.

module mem_channel_arb #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          ch_index_valid,
   output logic [NUM_CH-1:0]          ch_index_ready,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_index,
   input  logic [NUM_CH-1:0]          ch_write,
   input  logic [NUM_CH-1:0]          ch_burst,
   input  logic [NUM_CH*DATA_W-1:0]   ch_write_data,
   input  logic [NUM_CH-1:0]          ch_flush,
   output logic [DATA_W-1:0]          ch_read_data,
   output logic [NUM_CH-1:0]          ch_operation_done,
   output logic                       ddr_chip_enable,
   output logic [ADDR_W-1:0]          ddr_index,
   output logic                       ddr_write_enable,
   output logic                       ddr_burst_mode,
   output logic [DATA_W-1:0]          ddr_write_data,
   input  logic [DATA_W-1:0]          ddr_read_data,
   input  logic                       ddr_operation_done,
   input  logic                       ddr_ready
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Registered state and captured transaction
   state_t              state_q;
   logic [PTR_W-1:0]    grantIdx_q;
   logic [ADDR_W-1:0]   index_q;
   logic                write_q;
   logic                burst_q;
   logic [DATA_W-1:0]   writeData_q;
   logic [DATA_W-1:0]   readData_q;
   logic                chipEnable_q;
   logic [NUM_CH-1:0]   opDone_q;
   logic                cancel_q;

   // Combinational arbitration and payload selection
   logic                winFound_d;
   logic [PTR_W-1:0]    winIdx_d;
   logic                accept_d;
   logic [ADDR_W-1:0]   selIndex_d;
   logic                selWrite_d;
   logic                selBurst_d;
   logic [DATA_W-1:0]   selData_d;
   logic [NUM_CH-1:0]   readyVec_d;
   logic [NUM_CH-1:0]   grantVec_d;
   logic                flushHit_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam int SCAN_W = PTR_W + 1;

   logic [PTR_W-1:0]    ptr_q;
   logic [PTR_W-1:0]    ptrNext_d;
   logic [SCAN_W-1:0]   scan_d;

   // Scan the valids cyclically from the pointer; the first valid channel wins.
   // The scan index is one bit wider so ptr+i never overflows before the wrap.
   always_comb begin
      winFound_d = 1'b0;
      winIdx_d   = '0;
      scan_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         scan_d = {1'b0, ptr_q} + SCAN_W'(i);
         if (scan_d >= SCAN_W'(NUM_CH)) begin
            scan_d = scan_d - SCAN_W'(NUM_CH);
         end
         if (!winFound_d && ch_index_valid[scan_d[PTR_W-1:0]]) begin
            winFound_d = 1'b1;
            winIdx_d   = scan_d[PTR_W-1:0];
         end
      end
   end

   // Pointer moves to the channel after the winner, wrapping the last channel to 0
   always_comb begin
      if (winIdx_d == PTR_W'(NUM_CH - 1)) begin
         ptrNext_d = '0;
      end else begin
         ptrNext_d = winIdx_d + 1'b1;
      end
   end
`else
   // Fixed priority: the lowest-numbered valid channel wins.
   always_comb begin
      winFound_d = 1'b0;
      winIdx_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!winFound_d && ch_index_valid[i]) begin
            winFound_d = 1'b1;
            winIdx_d   = PTR_W'(i);
         end
      end
   end
`endif

   // Accept decision, winner payload mux, and decode of the stored grant.
   // Ready is combinational so a request is taken in the same cycle that
   // ddr_ready and the valid are both seen in IDLE.
   always_comb begin
      accept_d   = (state_q == IDLE) && ddr_ready && winFound_d;
      selIndex_d = '0;
      selWrite_d = 1'b0;
      selBurst_d = 1'b0;
      selData_d  = '0;
      readyVec_d = '0;
      grantVec_d = '0;
      flushHit_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (winIdx_d == PTR_W'(i)) begin
            selIndex_d    = ch_index[i*ADDR_W +: ADDR_W];
            selWrite_d    = ch_write[i];
            selBurst_d    = ch_burst[i];
            selData_d     = ch_write_data[i*DATA_W +: DATA_W];
            readyVec_d[i] = accept_d;
         end
         if (grantIdx_q == PTR_W'(i)) begin
            grantVec_d[i] = 1'b1;
            flushHit_d    = ch_flush[i];
         end
      end
   end

   // Main transaction FSM. Strobes default low each cycle and are set only
   // on the transition into the state where they must be visible.
   // A flush seen in the completion cycle of WAIT still suppresses the done.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         grantIdx_q   <= '0;
         index_q      <= '0;
         write_q      <= 1'b0;
         burst_q      <= 1'b0;
         writeData_q  <= '0;
         readData_q   <= '0;
         chipEnable_q <= 1'b0;
         opDone_q     <= '0;
         cancel_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q        <= '0;
`endif
      end else begin
         chipEnable_q <= 1'b0;
         opDone_q     <= '0;
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  index_q      <= selIndex_d;
                  write_q      <= selWrite_d;
                  burst_q      <= selBurst_d;
                  writeData_q  <= selData_d;
                  grantIdx_q   <= winIdx_d;
                  cancel_q     <= 1'b0;
                  chipEnable_q <= 1'b1;
                  state_q      <= ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  ptr_q        <= ptrNext_d;
`endif
               end
            end
            ISSUE: begin
               if (flushHit_d) begin
                  cancel_q <= 1'b1;
               end
               state_q <= WAIT;
            end
            WAIT: begin
               if (flushHit_d) begin
                  cancel_q <= 1'b1;
               end
               if (ddr_operation_done) begin
                  readData_q <= ddr_read_data;
                  opDone_q   <= (cancel_q || flushHit_d) ? '0 : grantVec_d;
                  state_q    <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Outputs are driven straight from registers, except the accept strobe
   assign ch_index_ready    = readyVec_d;
   assign ch_operation_done = opDone_q;
   assign ch_read_data      = readData_q;
   assign ddr_chip_enable   = chipEnable_q;
   assign ddr_index         = index_q;
   assign ddr_write_enable  = write_q;
   assign ddr_burst_mode    = burst_q;
   assign ddr_write_data    = writeData_q;

endmodule

// File: tb/tb_mem_channel_arb.sv
// tb_mem_channel_arb
// Scoreboard bench for mem_channel_arb with four channels. Stimulus pushes
// the expected grant, DDR command and completion for every request into
// queues; a monitor pops and compares whenever the DUT strobes an output.
// Expected grant orders follow MEM_ARB_ROUND_ROBIN_EN when it is defined.

module tb_mem_channel_arb;

   localparam int NUM_CH = 4;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 512;

   logic                      clock;
   logic                      reset;
   logic [NUM_CH-1:0]         ch_index_valid;
   logic [NUM_CH-1:0]         ch_index_ready;
   logic [NUM_CH*ADDR_W-1:0]  ch_index;
   logic [NUM_CH-1:0]         ch_write;
   logic [NUM_CH-1:0]         ch_burst;
   logic [NUM_CH*DATA_W-1:0]  ch_write_data;
   logic [NUM_CH-1:0]         ch_flush;
   logic [DATA_W-1:0]         ch_read_data;
   logic [NUM_CH-1:0]         ch_operation_done;
   logic                      ddr_chip_enable;
   logic [ADDR_W-1:0]         ddr_index;
   logic                      ddr_write_enable;
   logic                      ddr_burst_mode;
   logic [DATA_W-1:0]         ddr_write_data;
   logic [DATA_W-1:0]         ddr_read_data;
   logic                      ddr_operation_done;
   logic                      ddr_ready;

   mem_channel_arb #(
      .NUM_CH (NUM_CH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .ch_index_valid     (ch_index_valid),
      .ch_index_ready     (ch_index_ready),
      .ch_index           (ch_index),
      .ch_write           (ch_write),
      .ch_burst           (ch_burst),
      .ch_write_data      (ch_write_data),
      .ch_flush           (ch_flush),
      .ch_read_data       (ch_read_data),
      .ch_operation_done  (ch_operation_done),
      .ddr_chip_enable    (ddr_chip_enable),
      .ddr_index          (ddr_index),
      .ddr_write_enable   (ddr_write_enable),
      .ddr_burst_mode     (ddr_burst_mode),
      .ddr_write_data     (ddr_write_data),
      .ddr_read_data      (ddr_read_data),
      .ddr_operation_done (ddr_operation_done),
      .ddr_ready          (ddr_ready)
   );

   typedef struct {
      logic [NUM_CH-1:0] grant;
      logic [ADDR_W-1:0] idx;
      logic              we;
      logic              burst;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] rdata;
      int                k;
      bit                care;
   } txn_t;

   txn_t grantQ[$];
   txn_t cmdQ[$];
   txn_t doneQ[$];

   int checkCount = 0;
   int passCount  = 0;
   int cycle      = 0;
   int grantCycle = 0;
   int ceCycle    = 0;

   int                ddrK;
   logic [DATA_W-1:0] ddrLine;

   logic [ADDR_W-1:0] chIdx  [NUM_CH];
   logic              chWr   [NUM_CH];
   logic              chBurst[NUM_CH];
   logic [DATA_W-1:0] chData [NUM_CH];

   // Free-running clock and a cycle counter used for latency checks
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      forever begin
         @(posedge clock);
         cycle++;
      end
   end

   task automatic checkOutput(input string name, input logic [DATA_W-1:0] got,
                              input logic [DATA_W-1:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic noteUnexpected(input string name, input logic [DATA_W-1:0] got);
      checkCount++;
      $display("[TB] FAIL %s: got %0h with nothing expected", name, got);
   endtask

   // Copy per-channel payload tables onto the packed request ports
   task automatic applyPayload();
      for (int i = 0; i < NUM_CH; i++) begin
         ch_index[i*ADDR_W +: ADDR_W]      = chIdx[i];
         ch_write[i]                       = chWr[i];
         ch_burst[i]                       = chBurst[i];
         ch_write_data[i*DATA_W +: DATA_W] = chData[i];
      end
   endtask

   // Queue the expected grant, command and (optionally) completion of channel ch
   task automatic expectTxn(input int ch, input bit withDone);
      txn_t t;
      t.grant     = '0;
      t.grant[ch] = 1'b1;
      t.idx       = chIdx[ch];
      t.we        = chWr[ch];
      t.burst     = chBurst[ch];
      t.wdata     = chData[ch];
      t.rdata     = ddrLine;
      t.k         = ddrK;
      t.care      = !chWr[ch];
      grantQ.push_back(t);
      cmdQ.push_back(t);
      if (withDone) doneQ.push_back(t);
   endtask

   // Raise valids in mask, optionally hold ddr_ready low first, collect nGrants
   // accepts, then optionally pulse a flush flushOff cycles after the last accept.
   task automatic applyStimulus(input logic [NUM_CH-1:0] mask, input int nGrants,
                                input bit dropOnGrant, input int holdOff,
                                input int flushOff, input logic [NUM_CH-1:0] flushMask);
      int seen;
      int waited;
      int budget;
      logic [NUM_CH-1:0] live;
      live = mask;
      seen = 0;
      waited = 0;
      budget = 0;
      @(posedge clock); #1;
      ddr_ready      = (holdOff == 0);
      ch_index_valid = live;
      for (int i = 0; i < holdOff; i++) begin
         @(negedge clock);
         checkOutput("backpressureReady", DATA_W'(ch_index_ready), '0);
         checkOutput("backpressureCe", DATA_W'(ddr_chip_enable), '0);
         @(posedge clock); #1;
      end
      ddr_ready = 1'b1;
      while (seen < nGrants && budget < 200) begin
         @(negedge clock);
         if (ch_index_ready != '0) begin
            if (seen == 0) checkOutput("acceptLatency", DATA_W'(waited), '0);
            seen++;
            if (dropOnGrant) live = live & ~ch_index_ready;
            @(posedge clock); #1;
            if (seen == nGrants) live = '0;
            ch_index_valid = live;
         end else begin
            if (seen == 0) waited++;
            budget++;
            @(posedge clock); #1;
         end
      end
      ch_index_valid = '0;
      if (seen < nGrants) checkOutput("grantTimeout", DATA_W'(seen), DATA_W'(nGrants));
      if (flushOff > 0) begin
         repeat (flushOff - 1) @(posedge clock);
         #1;
         ch_flush = flushMask;
         @(posedge clock); #1;
         ch_flush = '0;
      end
      repeat (ddrK + 6) @(posedge clock);
   endtask

   // DDR model: after each command strobe, return ddrLine ddrK cycles later
   initial begin
      ddr_operation_done = 1'b0;
      ddr_read_data      = '0;
      forever begin
         @(negedge clock);
         if (ddr_chip_enable) begin
            repeat (ddrK) @(posedge clock);
            #1;
            ddr_operation_done = 1'b1;
            ddr_read_data      = ddrLine;
            @(posedge clock); #1;
            ddr_operation_done = 1'b0;
            ddr_read_data      = '0;
         end
      end
   end

   // Monitor: compare every strobe the DUT presents against the scoreboard queues
   initial begin : monitor
      txn_t t;
      forever begin
         @(negedge clock);
         if (ch_index_ready != '0) begin
            if (grantQ.size() == 0) begin
               noteUnexpected("grantVector", DATA_W'(ch_index_ready));
            end else begin
               t = grantQ.pop_front();
               checkOutput("grantVector", DATA_W'(ch_index_ready), DATA_W'(t.grant));
            end
            grantCycle = cycle;
         end
         if (ddr_chip_enable) begin
            if (cmdQ.size() == 0) begin
               noteUnexpected("chipEnable", DATA_W'(ddr_index));
            end else begin
               t = cmdQ.pop_front();
               checkOutput("ceLatency", DATA_W'(cycle - grantCycle), DATA_W'(1));
               checkOutput("ddrIndex", DATA_W'(ddr_index), DATA_W'(t.idx));
               checkOutput("ddrWriteEnable", DATA_W'(ddr_write_enable), DATA_W'(t.we));
               checkOutput("ddrBurstMode", DATA_W'(ddr_burst_mode), DATA_W'(t.burst));
               checkOutput("ddrWriteData", ddr_write_data, t.wdata);
            end
            ceCycle = cycle;
         end
         if (ch_operation_done != '0) begin
            if (doneQ.size() == 0) begin
               noteUnexpected("opDone", DATA_W'(ch_operation_done));
            end else begin
               t = doneQ.pop_front();
               checkOutput("opDoneVector", DATA_W'(ch_operation_done), DATA_W'(t.grant));
               checkOutput("doneLatency", DATA_W'(cycle - ceCycle), DATA_W'(t.k + 1));
               if (t.care) checkOutput("readData", ch_read_data, t.rdata);
            end
         end
      end
   end

   // Directed test sequence
   initial begin : stimulus
      int order[5];
      reset          = 1'b1;
      ch_index_valid = '0;
      ch_index       = '0;
      ch_write       = '0;
      ch_burst       = '0;
      ch_write_data  = '0;
      ch_flush       = '0;
      ddr_ready      = 1'b0;
      ddrK           = 1;
      ddrLine        = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         chIdx[i]   = '0;
         chWr[i]    = 1'b0;
         chBurst[i] = 1'b0;
         chData[i]  = '0;
      end

      // Reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("resetReady", DATA_W'(ch_index_ready), '0);
      checkOutput("resetDone", DATA_W'(ch_operation_done), '0);
      checkOutput("resetCe", DATA_W'(ddr_chip_enable), '0);
      checkOutput("resetDdrIndex", DATA_W'(ddr_index), '0);
      checkOutput("resetDdrWdata", ddr_write_data, '0);
      checkOutput("resetReadData", ch_read_data, '0);
      checkOutput("resetWe", DATA_W'(ddr_write_enable), '0);
      checkOutput("resetBurst", DATA_W'(ddr_burst_mode), '0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Fairness: all four channels continuously valid, DDR k=1
      ddrK    = 1;
      ddrLine = {16{32'h0F0F_1234}};
      for (int i = 0; i < NUM_CH; i++) begin
         chIdx[i]  = 64'h100 * 64'(i + 1);
         chData[i] = {16{32'hC0DE_0000 + 32'(i)}};
      end
      applyPayload();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      order = '{0, 1, 2, 3, 0};
`else
      order = '{0, 0, 0, 0, 0};
`endif
      for (int i = 0; i < 5; i++) expectTxn(order[i], 1'b1);
      applyStimulus(4'b1111, 5, 1'b0, 0, 0, '0);

      // Single read on channel 0, DDR done 3 cycles after the command
      chIdx[0] = 64'h1000;
      ddrK     = 3;
      ddrLine  = {64{8'hA5}};
      applyPayload();
      expectTxn(0, 1'b1);
      applyStimulus(4'b0001, 1, 1'b1, 0, 0, '0);
      checkOutput("readDataHold", ch_read_data, {64{8'hA5}});

      // Write path on channel 1 with burst
      chIdx[1]   = 64'h2040;
      chWr[1]    = 1'b1;
      chBurst[1] = 1'b1;
      chData[1]  = {32{16'hDEAD}};
      ddrK       = 2;
      ddrLine    = {16{32'h5555_AAAA}};
      applyPayload();
      expectTxn(1, 1'b1);
      applyStimulus(4'b0010, 1, 1'b1, 0, 0, '0);
      checkOutput("ddrIndexHold", DATA_W'(ddr_index), DATA_W'(64'h2040));
      checkOutput("ddrWeHold", DATA_W'(ddr_write_enable), DATA_W'(1));
      chWr[1]    = 1'b0;
      chBurst[1] = 1'b0;

      // Flush of the granted channel during WAIT suppresses its done
      chIdx[0] = 64'h3000;
      ddrK     = 3;
      ddrLine  = {16{32'h1111_2222}};
      applyPayload();
      expectTxn(0, 1'b0);
      applyStimulus(4'b0001, 1, 1'b1, 0, 3, 4'b0001);

      // Next request after a flush completes normally
      chIdx[0] = 64'h3040;
      ddrK     = 1;
      ddrLine  = {16{32'h3333_4444}};
      applyPayload();
      expectTxn(0, 1'b1);
      applyStimulus(4'b0001, 1, 1'b1, 0, 0, '0);

      // Flush on a channel that is not granted has no effect
      chIdx[1] = 64'h4000;
      ddrK     = 2;
      ddrLine  = {16{32'h5A5A_6B6B}};
      applyPayload();
      expectTxn(1, 1'b1);
      applyStimulus(4'b0010, 1, 1'b1, 0, 2, 4'b0001);

      // Flush during ISSUE also suppresses the done
      chIdx[2] = 64'h4440;
      ddrK     = 2;
      ddrLine  = {16{32'h7777_8888}};
      applyPayload();
      expectTxn(2, 1'b0);
      applyStimulus(4'b0100, 1, 1'b1, 0, 1, 4'b0100);

      // Backpressure: ddr_ready low for 5 cycles, then accept in the same cycle it rises
      chIdx[0] = 64'h5000;
      ddrK     = 1;
      ddrLine  = {16{32'h9999_AAAA}};
      applyPayload();
      expectTxn(0, 1'b1);
      applyStimulus(4'b0001, 1, 1'b1, 5, 0, '0);

      // Reset asserted while waiting for DDR; a late DDR done must be ignored
      chIdx[2] = 64'h6000;
      ddrK     = 8;
      ddrLine  = {64{8'h3C}};
      applyPayload();
      expectTxn(2, 1'b0);
      @(posedge clock); #1;
      ch_index_valid = 4'b0100;
      @(posedge clock); #1;
      ch_index_valid = '0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      checkOutput("midResetDone", DATA_W'(ch_operation_done), '0);
      checkOutput("midResetCe", DATA_W'(ddr_chip_enable), '0);
      checkOutput("midResetDdrIndex", DATA_W'(ddr_index), '0);
      checkOutput("midResetReadData", ch_read_data, '0);
      checkOutput("midResetWdata", ddr_write_data, '0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (12) @(posedge clock);
      #1;
      checkOutput("lateDdrDoneIgnored", ch_read_data, '0);

      // Pointer returns to 0 after reset: channel 0 beats channel 3
      chIdx[0] = 64'h7000;
      chIdx[3] = 64'h7FC0;
      ddrK     = 1;
      ddrLine  = {16{32'hBEEF_0001}};
      applyPayload();
      expectTxn(0, 1'b1);
      expectTxn(3, 1'b1);
      applyStimulus(4'b1001, 2, 1'b1, 0, 0, '0);

      // Every expected event must have been consumed
      checkOutput("grantQueueEmpty", DATA_W'(grantQ.size()), '0);
      checkOutput("cmdQueueEmpty", DATA_W'(cmdQ.size()), '0);
      checkOutput("doneQueueEmpty", DATA_W'(doneQ.size()), '0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Hard time limit so the bench always terminates
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish expected finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/mem_channel_arb.md
# mem_channel_arb

N-channel memory-bus arbiter that multiplexes cache-line requests from any number of requesters (icache, dcache, prefetchers, page walkers) onto the single DDR port. It is the parametrised successor to the fixed two-channel icache/dcache arbiter. It adds:
- configurable channel count and widths
- round-robin fairness
- per-channel flush that drops a completion without stalling the DDR transaction

It sits between the cache blocks and the core's top-level DDR pins.

## Interface
Parameters:
- NUM_CH, 2, number of requester channels (2..8)
- ADDR_W, 64, request index width
- DATA_W, 512, cache-line width

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- ch_index_valid  in  NUM_CH  per-channel request valid
- ch_index_ready  out  NUM_CH  per-channel accept strobe, one-hot or zero
- ch_index  in  NUM_CH*ADDR_W  per-channel index; channel i at [i*ADDR_W +: ADDR_W]
- ch_write  in  NUM_CH  1 = write, 0 = read
- ch_burst  in  NUM_CH  burst-mode request
- ch_write_data  in  NUM_CH*DATA_W  per-channel write line
- ch_flush  in  NUM_CH  cancel outstanding completion of channel i
- ch_read_data  out  DATA_W  shared read-return bus
- ch_operation_done  out  NUM_CH  one-hot completion pulse
- ddr_chip_enable  out  1  one-cycle command strobe
- ddr_index  out  ADDR_W  command index
- ddr_write_enable  out  1  command is write
- ddr_burst_mode  out  1  command is burst
- ddr_write_data  out  DATA_W  write line
- ddr_read_data  in  DATA_W  read return
- ddr_operation_done  in  1  DDR completion pulse
- ddr_ready  in  1  DDR can accept a command

## Operation
- The state machine has four states: IDLE, ISSUE, WAIT, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - If ddr_ready=1 and any ch_index_valid=1, the winner g is selected.
  - ch_index_ready[g]=1 for that cycle.
  - index, write, burst and write_data of g are captured into registers.
  - g is stored and the state moves to ISSUE.
- Requesters hold valid and payload stable until ready is seen. Deasserting valid before ready is legal and simply withdraws the request.
- ISSUE:
  - ddr_chip_enable=1 for exactly one cycle.
  - ddr_index, ddr_write_enable, ddr_burst_mode and ddr_write_data are driven from the captured registers.
  - The state moves to WAIT.
- The ddr_* payload outputs keep their last captured value until the next capture.
- WAIT: on ddr_operation_done=1, ddr_read_data is latched into ch_read_data and the state moves to RESP.
- RESP:
  - ch_operation_done[g]=1 for one cycle, unless the cancel flag is set, in which case no done is pulsed.
  - The state returns to IDLE.
  - ch_read_data holds its value until the next latch. For writes it holds the stale value and must be ignored.
- Cancel flag:
  - Set when ch_flush[g]=1 in any cycle of ISSUE, WAIT or RESP-entry.
  - Cleared on a new accept.
  - The DDR transaction always runs to completion; flush only suppresses the done pulse.
- Flush on a channel that is not granted has no effect. Its pending request may still be granted later, and the requester must drop its valid itself.
- ddr_operation_done arriving in IDLE, or in ISSUE before chip_enable has been driven, is ignored.

## Timing
- Reset values:
  - state IDLE
  - all ch_index_ready, ch_operation_done and ddr_chip_enable = 0
  - ddr_index, ddr_write_data, ch_read_data = 0
  - ddr_write_enable and ddr_burst_mode = 0
  - round-robin pointer = 0
  - cancel flag = 0
- Accept in cycle T → ddr_chip_enable in T+1 → ddr_operation_done in T+1+k (k≥1) → ch_operation_done in T+2+k.
- The earliest next accept is in the RESP-exit cycle, i.e. T+3+k.
- Minimum turnaround between chip_enable strobes is 4 cycles with k=1.
- ddr_ready=0 in IDLE blocks accept; valids stay pending and no ready is issued.
- Reset asserted mid-transaction returns to IDLE immediately:
  - No done is pulsed.
  - The pointer resets to 0.
  - The DDR side must also be reset by the system.
- Arbitration arithmetic:
  - The pointer is a $clog2(NUM_CH) counter.
  - On accept it is set to (g+1) mod NUM_CH, wrapping NUM_CH-1 → 0.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - The winner is the first valid channel scanning cyclically from the pointer.
  - Each channel waits at most NUM_CH-1 grants.
- Not defined:
  - Fixed priority: the lowest-numbered valid channel wins.
  - The pointer register is not built; channel 0 can starve the others.
- All other behaviour is identical in both builds.

## Test plan
- Single read: NUM_CH=2, ch0 valid, index 0x1000, ddr_ready=1, DDR done after 3 cycles returning line 0xA5…A5 → ch_index_ready[0] in T, chip_enable in T+1 with ddr_index=0x1000 and write_enable=0, ch_operation_done=2'b01 in T+5 with ch_read_data=0xA5…A5.
- Fairness with round robin: NUM_CH=4, all four valid continuously with DDR k=1 → grant order 0,1,2,3,0 (wrap); without the macro → 0,0,0,0.
- Write path: ch1 write, index 0x2040, data 0xDEAD…, burst=1 → chip_enable with write_enable=1, burst_mode=1, ddr_write_data=0xDEAD…; done=2'b10.
- Flush: ch0 read granted, ch_flush[0]=1 during WAIT → DDR still sees one chip_enable, no ch_operation_done, next request accepted normally.
- Backpressure: ddr_ready=0 for 5 cycles with ch0 valid → no ready and no chip_enable; ddr_ready rises → accept the same cycle.
- Reset mid-op: assert reset in WAIT → state IDLE and all outputs 0 next edge; a ddr_operation_done after reset release produces no done.
